// File: rtl/bldc_gate_driver.sv
// bldc_gate_driver: turns the 6-bit commutation pattern into six gate drives for a
// 3-phase bridge. High sides are chopped by an edge-aligned PWM, every switch-off is
// followed by a dead-time gap, and an external overcurrent fault is latched and
// forces all gates off.
// Optional feature: define BLDC_GATE_BRAKE_EN to make brake=1 request all low sides.
module bldc_gate_driver #(
    parameter int unsigned CNT_WIDTH  = 11,
    parameter int unsigned PERIOD     = 1349,
    parameter int unsigned DEAD_TICKS = 27
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] duty,
    input  logic [5:0]           phase_enable,
    input  logic                 fault_n,
    input  logic                 fault_clear,
    input  logic                 brake,
    output logic [2:0]           gate_hi,
    output logic [2:0]           gate_lo,
    output logic                 fault_latched,
    output logic                 pwm_sync
);

    localparam int unsigned          DEAD_W    = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [DEAD_W-1:0]    DEAD_LOAD = DEAD_W'(DEAD_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_TOP   = CNT_WIDTH'(PERIOD);

    // Per-leg states
    localparam logic [1:0] StOff  = 2'd0;
    localparam logic [1:0] StHi   = 2'd1;
    localparam logic [1:0] StLo   = 2'd2;
    localparam logic [1:0] StDead = 2'd3;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] shadow_q;
    logic                 pwm_sync_q;
    logic                 wrap;
    logic                 pwm_on;

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 sync3_q;
    logic                 fault_q;
    logic                 fault_set;
    logic                 force_off;

    logic [1:0]           req     [3];
    logic [1:0]           state_q [3];
    logic [1:0]           state_d [3];
    logic [DEAD_W-1:0]    dead_q  [3];
    logic [DEAD_W-1:0]    dead_d  [3];
    logic [2:0]           gate_hi_q;
    logic [2:0]           gate_lo_q;

    assign wrap   = enable && (cnt_q == CNT_TOP);
    assign pwm_on = (cnt_q < shadow_q);

    // PWM counter, duty shadow (reloaded only at the wrap) and wrap pulse
    always_ff @(posedge pclk) begin
        if (prst) begin
            cnt_q      <= '0;
            shadow_q   <= '0;
            pwm_sync_q <= 1'b0;
        end else begin
            pwm_sync_q <= wrap;
            if (!enable || wrap) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (wrap) begin
                shadow_q <= duty;
            end
        end
    end

    // Two consecutive synchronised lows qualify a fault; this filters one-cycle glitches
    assign fault_set = !sync2_q && !sync3_q;
    assign force_off = !enable || fault_set || fault_q;

    // Fault synchroniser, glitch filter and sticky flag (set beats clear)
    always_ff @(posedge pclk) begin
        if (prst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            fault_q <= 1'b0;
        end else begin
            sync1_q <= fault_n;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (fault_set) begin
                fault_q <= 1'b1;
            end else if (fault_clear && sync2_q) begin
                fault_q <= 1'b0;
            end
        end
    end

`ifndef BLDC_GATE_BRAKE_EN
    // Brake input has no function in this build
    logic unused_brake;
    assign unused_brake = brake;
`endif

    // Per-leg request decode; both bits set is illegal and treated as off
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (phase_enable[2*i+1] && !phase_enable[2*i] && pwm_on) begin
                req[i] = StHi;
            end else if (phase_enable[2*i] && !phase_enable[2*i+1]) begin
                req[i] = StLo;
            end else begin
                req[i] = StOff;
            end
`ifdef BLDC_GATE_BRAKE_EN
            if (brake) begin
                req[i] = StLo;
            end
`endif
        end
    end

    // Leg next-state: any departure from a conducting state passes through dead time
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            dead_d[i]  = dead_q[i];
            if (force_off) begin
                state_d[i] = StOff;
                dead_d[i]  = '0;
            end else begin
                case (state_q[i])
                    StOff: begin
                        state_d[i] = req[i];
                    end
                    StHi, StLo: begin
                        if (req[i] != state_q[i]) begin
                            state_d[i] = StDead;
                            dead_d[i]  = DEAD_LOAD;
                        end
                    end
                    default: begin
                        if (dead_q[i] == '0) begin
                            state_d[i] = req[i];
                        end else begin
                            dead_d[i] = dead_q[i] - DEAD_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Leg state and gate registers; gates decode the next state so they track it exactly
    always_ff @(posedge pclk) begin
        if (prst) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= StOff;
                dead_q[i]  <= '0;
            end
            gate_hi_q <= '0;
            gate_lo_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i]   <= state_d[i];
                dead_q[i]    <= dead_d[i];
                gate_hi_q[i] <= (state_d[i] == StHi);
                gate_lo_q[i] <= (state_d[i] == StLo);
            end
        end
    end

    assign gate_hi       = gate_hi_q;
    assign gate_lo       = gate_lo_q;
    assign fault_latched = fault_q;
    assign pwm_sync      = pwm_sync_q;

endmodule

// File: tb/tb_bldc_gate_driver.sv
// tb_bldc_gate_driver: directed test-plan sequences followed by random stimulus, all
// checked every cycle against a deadline-based behavioural model of the gate driver.
// Honours BLDC_GATE_BRAKE_EN when defined.
module tb_bldc_gate_driver;

    localparam int PERIOD = 1349;
    localparam int DEAD   = 27;
    localparam int OUT_OFF = 0;
    localparam int OUT_HI  = 1;
    localparam int OUT_LO  = 2;

    logic        pclk = 1'b0;
    logic        prst;
    logic        enable;
    logic [10:0] duty;
    logic [5:0]  phase_enable;
    logic        fault_n;
    logic        fault_clear;
    logic        brake;
    logic [2:0]  gate_hi;
    logic [2:0]  gate_lo;
    logic        fault_latched;
    logic        pwm_sync;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state
    int     m_cnt = 0;
    int     m_shadow = 0;
    bit     m_sync = 1'b0;
    bit     m_s1 = 1'b1, m_s2 = 1'b1, m_s3 = 1'b1;
    bit     m_fault = 1'b0;
    int     m_out[3];
    longint m_release[3];
    longint cyc = 0;

    bldc_gate_driver dut (
        .pclk          (pclk),
        .prst          (prst),
        .enable        (enable),
        .duty          (duty),
        .phase_enable  (phase_enable),
        .fault_n       (fault_n),
        .fault_clear   (fault_clear),
        .brake         (brake),
        .gate_hi       (gate_hi),
        .gate_lo       (gate_lo),
        .fault_latched (fault_latched),
        .pwm_sync      (pwm_sync)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // Model: a leg that leaves a conducting state stays dark until a release cycle
    always @(posedge pclk) begin : model
        int req;
        bit pwm_on, wrap, fset, frc, hb, lb;
        if (prst) begin
            m_cnt = 0; m_shadow = 0; m_sync = 1'b0; m_fault = 1'b0;
            m_s1 = 1'b1; m_s2 = 1'b1; m_s3 = 1'b1;
            for (int i = 0; i < 3; i++) begin
                m_out[i] = OUT_OFF;
                m_release[i] = 0;
            end
        end else begin
            wrap   = enable && (m_cnt == PERIOD);
            pwm_on = m_cnt < m_shadow;
            fset   = !m_s2 && !m_s3;
            frc    = !enable || fset || m_fault;
            for (int i = 0; i < 3; i++) begin
                hb = phase_enable[2*i+1];
                lb = phase_enable[2*i];
                req = (hb && !lb && pwm_on) ? OUT_HI : (lb && !hb) ? OUT_LO : OUT_OFF;
`ifdef BLDC_GATE_BRAKE_EN
                if (brake) req = OUT_LO;
`endif
                if (frc) begin
                    m_out[i] = OUT_OFF;
                    m_release[i] = 0;
                end else if (m_out[i] != OUT_OFF) begin
                    if (req != m_out[i]) begin
                        m_out[i] = OUT_OFF;
                        m_release[i] = cyc + DEAD;
                    end
                end else if (cyc >= m_release[i]) begin
                    m_out[i] = req;
                end
            end
            if (fset) m_fault = 1'b1;
            else if (fault_clear && m_s2) m_fault = 1'b0;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = fault_n;
            m_sync = wrap;
            if (!enable || wrap) m_cnt = 0;
            else m_cnt = m_cnt + 1;
            if (wrap) m_shadow = int'(duty);
        end
        cyc++;
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge pclk) begin : compare
        logic [2:0] eh, el;
        if (check_en) begin
            for (int i = 0; i < 3; i++) begin
                eh[i] = (m_out[i] == OUT_HI);
                el[i] = (m_out[i] == OUT_LO);
            end
            chk("gate_hi", int'(gate_hi), int'(eh));
            chk("gate_lo", int'(gate_lo), int'(el));
            chk("fault_latched", int'(fault_latched), int'(m_fault));
            chk("pwm_sync", int'(pwm_sync), int'(m_sync));
            chk("shoot_through", int'(gate_hi & gate_lo), 0);
        end
    end

    task automatic wait_sync();
        int n = 0;
        while (!pwm_sync && n < 1400) begin
            tick(1);
            n++;
        end
        chk("wait_sync", int'(pwm_sync), 1);
    endtask

    // Starts on a pwm_sync cycle, counts one period of gate_hi[0], ends on the next sync
    task automatic measure(input string name, input int exp_hi);
        int hi = 0;
        for (int k = 0; k <= PERIOD; k++) begin
            if (gate_hi[0]) hi++;
            tick(1);
        end
        chk(name, hi, exp_hi);
        chk("period_sync", int'(pwm_sync), 1);
    endtask

    task automatic count_dead(input string name);
        int n = 0;
        while (!gate_lo[0] && n < 100) begin
            n++;
            tick(1);
        end
        chk(name, n, DEAD);
    endtask

    initial begin : stim
        int hi, flow, n;
        prst = 1'b1; enable = 1'b0; duty = '0; phase_enable = '0;
        fault_n = 1'b1; fault_clear = 1'b0; brake = 1'b0;
        tick(3);
        check_en = 1'b1;
        chk("rst_gate_hi", int'(gate_hi), 0);
        chk("rst_gate_lo", int'(gate_lo), 0);
        chk("rst_fault", int'(fault_latched), 0);
        chk("rst_sync", int'(pwm_sync), 0);

        // A high side chopped, B low side on
        prst = 1'b0; enable = 1'b1; duty = 11'd675; phase_enable = 6'b000110;
        tick(1);
        chk("b_lo_latency", int'(gate_lo), 3'b010);
        chk("a_hi_first_period", int'(gate_hi), 0);
        wait_sync();
        measure("hi_675", 675);

        // A high -> A low through dead time
        tick(1);
        chk("a_hi_on", int'(gate_hi[0]), 1);
        phase_enable = 6'b000101;
        tick(1);
        chk("a_hi_drop", int'(gate_hi[0]), 0);
        count_dead("dead_hi_to_lo");

        // Mid-period duty change takes effect only after the next wrap
        phase_enable = 6'b000110;
        wait_sync();
        hi = 0;
        for (int k = 0; k <= PERIOD; k++) begin
            if (k == 200) duty = 11'd100;
            if (gate_hi[0]) hi++;
            tick(1);
        end
        chk("hi_unchanged", hi, 675);
        chk("sync_after_change", int'(pwm_sync), 1);
        duty = 11'd0;
        measure("hi_100", 100);
        duty = 11'd2047;
        measure("hi_0", 0);
        measure("hi_full_first", PERIOD);
        duty = 11'd675;
        measure("hi_full", PERIOD + 1);

        // Illegal pattern on A, nothing on B/C
        phase_enable = 6'b000011;
        tick(1);
        chk("illegal_hi", int'(gate_hi), 0);
        chk("illegal_lo", int'(gate_lo), 0);
        tick(40);
        chk("illegal_hi_late", int'(gate_hi), 0);
        chk("illegal_lo_late", int'(gate_lo), 0);

        // Fault filter, latch, ignored clear, then clear
        phase_enable = 6'b000110;
        tick(40);
        chk("pre_fault_b_lo", int'(gate_lo[1]), 1);
        fault_n = 1'b0; tick(1); fault_n = 1'b1;
        tick(6);
        chk("glitch_no_latch", int'(fault_latched), 0);
        chk("glitch_b_lo", int'(gate_lo[1]), 1);
        fault_n = 1'b0; tick(3); fault_n = 1'b1;
        tick(2);
        chk("fault_latch", int'(fault_latched), 1);
        chk("fault_hi_off", int'(gate_hi), 0);
        chk("fault_lo_off", int'(gate_lo), 0);
        fault_n = 1'b0; tick(4);
        fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
        chk("clear_ignored", int'(fault_latched), 1);
        fault_n = 1'b1; tick(4);
        chk("still_latched", int'(fault_latched), 1);
        fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
        chk("fault_cleared", int'(fault_latched), 0);
        chk("clear_gates_off", int'(gate_lo), 0);
        tick(1);
        chk("resume_b_lo", int'(gate_lo[1]), 1);

`ifdef BLDC_GATE_BRAKE_EN
        // Brake: every leg to low side via dead time, fault still overrides
        wait_sync();
        tick(1);
        chk("brake_pre_a_hi", int'(gate_hi[0]), 1);
        brake = 1'b1;
        tick(1);
        chk("brake_a_drop", int'(gate_hi[0]), 0);
        count_dead("brake_dead");
        chk("brake_all_lo", int'(gate_lo), 3'b111);
        fault_n = 1'b0;
        n = 0;
        while (!fault_latched && n < 10) begin
            tick(1);
            n++;
        end
        chk("brake_fault", int'(fault_latched), 1);
        chk("brake_fault_lo", int'(gate_lo), 0);
        fault_n = 1'b1; tick(4);
        fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
        brake = 1'b0;
`endif

        // Random stimulus
        flow = 0;
        for (int k = 0; k < 20000 && errors < 100; k++) begin
            prst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 39) == 0) phase_enable = 6'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                case ($urandom_range(0, 4))
                    0: duty = 11'd0;
                    1: duty = 11'd1349;
                    2: duty = 11'd1350;
                    3: duty = 11'd2047;
                    default: duty = 11'($urandom_range(0, 1400));
                endcase
            end
            if ($urandom_range(0, 1999) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 49) == 0) enable = 1'b1;
            if (flow > 0) begin
                flow--;
                fault_n = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                flow = int'($urandom_range(0, 3));
                fault_n = 1'b0;
            end else begin
                fault_n = 1'b1;
            end
            fault_clear = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) brake = !brake;
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bldc_gate_driver.md
Name: bldc_gate_driver

Overview:
- Downstream stage of the APB2 BLDC commutation peripheral: consumes its 6-bit `phase_enable` commutation pattern and produces the six gate-drive signals for the 3-phase inverter bridge.
- Chops the high-side switches with an edge-aligned PWM and inserts dead time on every switch-off.
- Latches an external overcurrent fault and forces all gates off until software clears it.
- Runs on the 54 MHz APB clock domain.

Parameters:
- CNT_WIDTH, 11, width of PWM counter and duty input
- PERIOD, 1349, counter terminal value; PWM period = PERIOD+1 clocks (40 kHz at 54 MHz)
- DEAD_TICKS, 27, dead-time length in clocks (500 ns at 54 MHz); must be >= 1

Ports:
- pclk  input  1  block clock (APB pclk)
- prst  input  1  synchronous reset, active-high
- enable  input  1  master output enable; 0 forces all gates off
- duty  input  CNT_WIDTH  requested high-side on-time in clocks per period
- phase_enable  input  6  commutation request; bit 2i+1 = phase i high side, bit 2i = phase i low side (i = 0 A, 1 B, 2 C)
- fault_n  input  1  asynchronous overcurrent input, active-low
- fault_clear  input  1  single-cycle pulse to clear latched fault
- brake  input  1  active-braking request (used only with optional feature)
- gate_hi  output  3  high-side gate drive, bit i = phase i
- gate_lo  output  3  low-side gate drive, bit i = phase i
- fault_latched  output  1  fault sticky flag
- pwm_sync  output  1  one-cycle pulse when counter wraps from PERIOD to 0

Behaviour:
- Reset (prst=1 at a pclk edge): counter=0, duty shadow=0, all legs OFF, gate_hi=gate_lo=0, fault_latched=0, pwm_sync=0, synchroniser flops=1.
- PWM counter:
  - counts 0..PERIOD, then wraps to 0;
  - held at 0 while enable=0;
  - pwm_sync is registered, high in the cycle the counter equals 0 after a wrap.
- Duty shadow: loaded from `duty` only on the wrap cycle.
  - pwm_on = (cnt < shadow);
  - shadow=0 gives 0% duty;
  - shadow > PERIOD gives 100% duty (no clamp needed).
- Per-leg request:
  - HI if hi bit & !lo bit & pwm_on;
  - LO if lo bit & !hi bit;
  - otherwise OFF. Both bits set is illegal and treated as OFF.
- Per-leg FSM, states OFF, HI, LO, DEAD:
  - OFF -> requested state on next edge.
  - HI/LO -> DEAD whenever the request differs from the current state; dead counter loaded with DEAD_TICKS-1.
  - DEAD: both gates 0; dead counter decrements; at 0, go to the current request (OFF, HI or LO), sampled that cycle.
  - A HI->LO or LO->HI path therefore always includes exactly DEAD_TICKS clocks with both gates low.
- Outputs are registered from the state: gate_hi[i] = (state==HI), gate_lo[i] = (state==LO). Never both 1, under any input sequence.
- Latency: a request change from OFF appears on the gates 1 clock later. From a conducting state, gates drop after 1 clock and the new gate asserts DEAD_TICKS clocks after that.
- Fault path:
  - fault_n passes through a 2-flop synchroniser.
  - Two consecutive synchronised lows set fault_latched; this is a glitch filter.
  - While fault_latched=1, all legs are forced OFF directly (no DEAD), gates 0 on the same edge that sets the flag.
- Fault clear:
  - fault_clear clears fault_latched only if the synchronised fault_n is 1 that cycle; otherwise the pulse is ignored.
  - If fault_clear and a new fault qualification occur in the same cycle, the set wins.
- enable=0: all legs forced OFF, dead counters cleared.
- Re-enable or fault clear: legs start from OFF and follow the normal transitions.
- Reset mid-dead-time: immediate OFF, no pending transition retained.

Optional Feature:
- Macro: BLDC_GATE_BRAKE_EN.
- With the macro defined:
  - brake=1 (and no fault, enable=1) overrides phase_enable; every leg's request is LO, so all low sides on via the normal DEAD sequence.
  - brake has lower priority than fault and enable=0.
- Without the macro: the brake port exists but is ignored; no brake logic is synthesised.

Test Plan:
- Reset then enable=1, duty=675, phase_enable=6'b00_01_10 (A hi, B lo) -> gate_lo[1] high 1 clk after request; gate_hi[0] high for 675 of every 1350 clocks; pwm_sync every 1350 clocks.
- Change phase_enable from A-hi to A-lo while gate_hi[0]=1 -> gate_hi[0] falls next clk; gate_lo[0] rises exactly 27 clocks later; gates never both high.
- duty written mid-period 675->100 -> on-time unchanged until next pwm_sync, then 100 clocks; duty=0 -> no hi pulses; duty=2047 -> hi continuous.
- phase_enable=6'b000011 (both A bits) -> gate_hi[0]=gate_lo[0]=0.
- Fault sequence:
  - fault_n low 1 clk -> no latch.
  - fault_n low 3 clks -> fault_latched=1, all gates 0.
  - fault_clear while fault_n low -> still latched.
  - After fault_n high: clear -> gates resume from OFF.
- With BLDC_GATE_BRAKE_EN, brake=1 while A hi -> A through DEAD (27 clocks) then all gate_lo=3'b111; assert fault -> all off immediately.
